// File: rtl/mac_col_driver_pkg.sv
// mac_col_driver_pkg
//   Shared definitions for the MAC column issue path.
//   - Default lane geometry (BW_DEF bits per lane, PR_DEF lanes), kept in
//     step with the column itself.
//   - Instruction codes placed on the column's i_inst input.
//   - State encoding for the column driver FSM.
//   - A helper that clamps a requested Q-vector count to the job maximum.
package mac_col_driver_pkg;

  localparam int BW_DEF          = 8;
  localparam int PR_DEF          = 8;
  localparam int TOTAL_CYCLE_DEF = 8;
  localparam int COL_LAT_DEF     = 3;

  // Column instruction codes; 2'b11 is reserved and never issued.
  localparam logic [1:0] INST_NOP   = 2'b00;
  localparam logic [1:0] INST_KLOAD = 2'b01;
  localparam logic [1:0] INST_EXEC  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    EXEC  = 2'b10,
    DRAIN = 2'b11
  } state_t;

  // Requests larger than the job maximum are silently capped.
  function automatic int clampNq(input int nq, input int maxQ);
    return (nq > maxQ) ? maxQ : nq;
  endfunction

endpackage

// File: rtl/mac_col_driver_if.sv
// mac_col_driver_if
//   Vector stream and column-issue bundle between the Q/K buffer readout,
//   the column driver and the first MAC column.
//   Signals:
//     vec_in    : lane vector, lane 0 in bits [BW-1:0]
//     vec_valid : vec_in carries data
//     vec_ready : driver accepts vec_in this cycle
//     q_out     : vector presented to the column q_in
//     inst_out  : instruction presented to the column i_inst
//   Modports:
//     master : upstream side (drives the vector stream, observes issue)
//     slave  : the driver (consumes the stream, drives the column)
interface mac_col_driver_if
  import mac_col_driver_pkg::*;
#(
  parameter int BW = BW_DEF,
  parameter int PR = PR_DEF
);

  logic [PR*BW-1:0] vec_in;
  logic             vec_valid;
  logic             vec_ready;
  logic [PR*BW-1:0] q_out;
  logic [1:0]       inst_out;

  modport master (
    output vec_in, vec_valid,
    input  vec_ready, q_out, inst_out
  );

  modport slave (
    input  vec_in, vec_valid,
    output vec_ready, q_out, inst_out
  );

endinterface

// File: rtl/mac_col_driver.sv
// mac_col_driver
//   Issue-side sequencer for one MAC column. A job issues one kernel-load
//   vector followed by up to TOTAL_CYCLE query-execute vectors taken from a
//   valid/ready stream, inserts NOPs whenever upstream stalls, then waits
//   out the column pipeline (COL_LAT cycles) and pulses done.
//   Ports:
//     clk    : rising-edge clock
//     reset  : asynchronous, active-high
//     start  : one-cycle job request, honoured only while idle
//     n_q    : Q vectors for the job, sampled with an accepted start
//     vbus   : vector stream in / column issue out (slave modport)
//     busy   : high whenever a job is in progress
//     done   : one-cycle completion pulse
module mac_col_driver
  import mac_col_driver_pkg::*;
#(
  parameter int BW          = BW_DEF,
  parameter int PR          = PR_DEF,
  parameter int TOTAL_CYCLE = TOTAL_CYCLE_DEF,
  parameter int COL_LAT     = COL_LAT_DEF,
  localparam int NQW        = $clog2(TOTAL_CYCLE + 1),
  localparam int DW         = $clog2(COL_LAT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NQW-1:0]   n_q,
  mac_col_driver_if.slave  vbus,
  output logic             busy,
  output logic             done
);

  state_t           state_q;
  logic [NQW-1:0]   nq_q;
  logic [NQW-1:0]   nq_d;
  logic [NQW-1:0]   qCnt_q;
  logic [NQW-1:0]   qCnt_d;
  logic [DW-1:0]    drainCnt_q;
  logic [PR*BW-1:0] qOut_q;
  logic [1:0]       inst_q;
  logic             done_q;

  // Clamped job length and the Q counter after one more accepted vector.
  always_comb begin
    nq_d   = NQW'(clampNq(int'(n_q), TOTAL_CYCLE));
    qCnt_d = qCnt_q + NQW'(1);
  end

  // Main sequencer. Every column-facing output is registered here so the
  // column sees a clean one-cycle-latency issue stream. The instruction
  // register defaults to NOP each cycle; only an actual handshake in LOAD
  // or EXEC overrides it, so stalls and draining naturally bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      nq_q       <= '0;
      qCnt_q     <= '0;
      drainCnt_q <= '0;
      qOut_q     <= '0;
      inst_q     <= INST_NOP;
      done_q     <= 1'b0;
    end else begin
      inst_q <= INST_NOP;
      case (state_q)
        IDLE: begin
          if (start) begin
            nq_q       <= nq_d;
            qCnt_q     <= '0;
            drainCnt_q <= '0;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          if (vbus.vec_valid) begin
            qOut_q  <= vbus.vec_in;
            inst_q  <= INST_KLOAD;
            state_q <= (nq_q == '0) ? DRAIN : EXEC;
          end
        end
        EXEC: begin
          if (vbus.vec_valid) begin
            qOut_q <= vbus.vec_in;
            inst_q <= INST_EXEC;
            qCnt_q <= qCnt_d;
            if (qCnt_d == nq_q) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // done stays high for exactly one cycle while still in DRAIN, so
          // a start coinciding with done is ignored by construction.
          if (done_q) begin
            done_q     <= 1'b0;
            drainCnt_q <= '0;
            state_q    <= IDLE;
          end else if (drainCnt_q == DW'(COL_LAT)) begin
            done_q <= 1'b1;
          end else begin
            drainCnt_q <= drainCnt_q + DW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Ready and busy are pure decodes of the state register, keeping any
  // input-to-output combinational path out of the handshake.
  assign vbus.vec_ready = (state_q == LOAD) || (state_q == EXEC);
  assign vbus.q_out     = qOut_q;
  assign vbus.inst_out  = inst_q;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;

endmodule

// File: tb/tb_mac_col_driver.sv
// tb_mac_col_driver
//   Self-checking bench for mac_col_driver. A transaction-level model
//   (accepts remaining, edges left until done) predicts every output each
//   cycle; directed jobs additionally pin exact cycle counts and values.
module tb_mac_col_driver;
  import mac_col_driver_pkg::*;

  localparam int BW  = 8;
  localparam int PR  = 8;
  localparam int TC  = 8;
  localparam int CL  = 3;
  localparam int NQW = $clog2(TC + 1);
  localparam int VW  = PR * BW;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [NQW-1:0] n_q;
  logic           busy;
  logic           done;

  int total = 0;
  int bad   = 0;

  mac_col_driver_if #(.BW(BW), .PR(PR)) vbus ();

  mac_col_driver #(
    .BW(BW), .PR(PR), .TOTAL_CYCLE(TC), .COL_LAT(CL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .n_q(n_q),
    .vbus(vbus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Model state and observation traces
  int             cyc = 0;
  bit             mBusy = 0;
  int             mNeed = 0;
  bit             mFirst = 0;
  int             mWait = 0;
  bit             mDone = 0;
  logic [VW-1:0]  mQ = '0;
  logic [1:0]     mInst = INST_NOP;
  int             startCyc = 0;
  int             doneCyc = 0;
  int             doneCount = 0;
  bit             prevDone = 0;
  logic [1:0]     traceInst[$];
  logic [VW-1:0]  traceQ[$];
  bit             traceRdy[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [VW-1:0] allLanes(input int v);
    logic [7:0] b;
    b = v[7:0];
    return {PR{b}};
  endfunction

  // Per-cycle scoreboard: inputs are snapshotted mid-cycle, the model is
  // advanced by one edge, then all outputs are compared just after it.
  initial begin : scoreboard
    bit             sR, sS, sV;
    logic [NQW-1:0] sN;
    logic [VW-1:0]  sD;
    forever begin
      @(negedge clk);
      sR = reset; sS = start; sN = n_q; sV = vbus.vec_valid; sD = vbus.vec_in;
      @(posedge clk);
      #1;
      cyc++;
      mInst = INST_NOP;
      if (sR) begin
        mBusy = 0; mNeed = 0; mDone = 0; mWait = 0; mQ = '0;
      end else if (!mBusy) begin
        if (sS) begin
          mBusy = 1;
          mNeed = 1 + ((int'(sN) > TC) ? TC : int'(sN));
          mFirst = 1;
          startCyc = cyc;
        end
      end else if (mNeed > 0) begin
        if (sV) begin
          mQ = sD;
          mInst = mFirst ? INST_KLOAD : INST_EXEC;
          mFirst = 0;
          mNeed--;
          if (mNeed == 0) mWait = CL + 1;
        end
      end else if (mDone) begin
        mDone = 0;
        mBusy = 0;
      end else begin
        mWait--;
        if (mWait == 0) mDone = 1;
      end
      checkOutput("q_out", vbus.q_out, mQ);
      checkOutput("inst_out", vbus.inst_out, mInst);
      checkOutput("vec_ready", vbus.vec_ready, mBusy && (mNeed > 0));
      checkOutput("busy", busy, mBusy);
      checkOutput("done", done, mDone);
      if (done && !prevDone) begin
        doneCyc = cyc;
        doneCount++;
      end
      prevDone = done;
      traceInst.push_back(vbus.inst_out);
      traceQ.push_back(vbus.q_out);
      traceRdy.push_back(vbus.vec_ready);
    end
  end

  // Drive one vector-stream cycle's worth of inputs.
  task automatic applyStimulus(input bit s, input int nq, input bit v, input logic [VW-1:0] d);
    start = s;
    n_q = NQW'(nq);
    vbus.vec_valid = v;
    vbus.vec_in = d;
  endtask

  // Run one job. stallAfter>0 drops valid for 2 cycles after Q_stallAfter;
  // resetAtQ>0 fires an asynchronous reset between edges once Q_resetAtQ
  // is on the outputs. Returns start-to-done distance in cycles.
  task automatic runJob(input int nq, input int stallAfter, input bit randMode,
                        input bit midStart, input bit startOnDone, input int resetAtQ,
                        output int delay);
    logic [VW-1:0] vecs[20];
    int  accepted = 0;
    int  budget = 0;
    int  stallLeft = 0;
    bit  hs;
    bit  sawDone = 0;
    bit  finished = 0;
    for (int i = 0; i < 20; i++)
      vecs[i] = randMode ? {$urandom, $urandom} : ((i == 0) ? allLanes(1) : allLanes(i));
    delay = -1;
    @(posedge clk);
    #2;
    traceInst.delete(); traceQ.delete(); traceRdy.delete();
    applyStimulus(1'b1, nq, randMode ? 1'($urandom_range(0, 1)) : 1'b1, vecs[0]);
    while (!finished && budget < 300) begin
      @(negedge clk);
      hs = vbus.vec_ready && vbus.vec_valid;
      @(posedge clk);
      #2;
      budget++;
      start = 1'b0;
      if (hs) accepted++;
      if (resetAtQ > 0 && hs && accepted == resetAtQ + 1) begin
        checkOutput("rst_inflight_inst", vbus.inst_out, INST_EXEC);
        checkOutput("rst_inflight_q", vbus.q_out, allLanes(resetAtQ));
        #1;
        reset = 1'b1;
        #1;
        checkOutput("rst_async_q", vbus.q_out, 64'h0);
        checkOutput("rst_async_inst", vbus.inst_out, INST_NOP);
        checkOutput("rst_async_busy", busy, 1'b0);
        checkOutput("rst_async_ready", vbus.vec_ready, 1'b0);
        checkOutput("rst_async_done", done, 1'b0);
        vbus.vec_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        finished = 1;
      end else begin
        if (midStart && hs && accepted == 4) start = 1'b1;
        if (stallAfter > 0 && hs && accepted == stallAfter + 1) stallLeft = 2;
        vbus.vec_in = vecs[accepted];
        if (stallLeft > 0) begin
          vbus.vec_valid = 1'b0;
          stallLeft--;
        end else begin
          vbus.vec_valid = randMode ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (done) begin
          sawDone = 1;
          if (startOnDone) start = 1'b1;
        end else if (sawDone) begin
          finished = 1;
          delay = doneCyc - startCyc;
        end
      end
    end
    checkOutput("job_finished", finished, 1'b1);
    start = 1'b0;
    vbus.vec_valid = 1'b0;
  endtask

  task automatic countTrace(output int kc, output int ec, output logic [VW-1:0] kv, output int ki);
    kc = 0; ec = 0; kv = '0; ki = 0;
    foreach (traceInst[j]) begin
      if (traceInst[j] == INST_KLOAD) begin
        kc++; kv = traceQ[j]; ki = j;
      end else if (traceInst[j] == INST_EXEC) begin
        ec++;
      end
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    int d, kc, ec, ki, run, i3, j, nops, holdOk, doneBefore, nq, nqc, execSeen, idx8;
    logic [VW-1:0] kv;
    reset = 1'b1;
    applyStimulus(1'b0, 0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_q", vbus.q_out, 64'h0);
    checkOutput("reset_inst", vbus.inst_out, INST_NOP);
    checkOutput("reset_ready", vbus.vec_ready, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Basic job, n_q=8, no stalls
    runJob(8, 0, 0, 0, 0, 0, d);
    countTrace(kc, ec, kv, ki);
    checkOutput("t1_kload_count", kc, 1);
    checkOutput("t1_kload_val", kv, 64'h0101_0101_0101_0101);
    checkOutput("t1_exec_count", ec, 8);
    run = 0;
    for (int k = 1; k <= 8; k++)
      if (ki + k < traceInst.size())
        if (traceInst[ki + k] == INST_EXEC && traceQ[ki + k] == allLanes(k)) run++;
    checkOutput("t1_exec_run", run, 8);
    checkOutput("t1_done_delay", d, 13);

    // Two-cycle stall after Q_3
    runJob(8, 3, 0, 0, 0, 0, d);
    i3 = -1;
    foreach (traceInst[k])
      if (i3 < 0 && traceInst[k] == INST_EXEC && traceQ[k] == allLanes(3)) i3 = k;
    nops = 0; holdOk = 0;
    j = i3 + 1;
    while (i3 >= 0 && j < traceInst.size() && traceInst[j] == INST_NOP) begin
      if (traceQ[j] == allLanes(3)) holdOk++;
      nops++; j++;
    end
    checkOutput("t2_nop_count", nops, 2);
    checkOutput("t2_q_hold", holdOk, 2);
    checkOutput("t2_next_exec_q4", (j < traceInst.size()) && traceInst[j] == INST_EXEC && traceQ[j] == allLanes(4), 1'b1);
    checkOutput("t2_done_delay", d, 15);

    // n_q=0: kernel load only
    runJob(0, 0, 0, 0, 0, 0, d);
    countTrace(kc, ec, kv, ki);
    checkOutput("t3_kload_count", kc, 1);
    checkOutput("t3_exec_count", ec, 0);
    checkOutput("t3_done_delay", d, 5);

    // n_q=12 clamped to 8
    runJob(12, 0, 0, 0, 0, 0, d);
    countTrace(kc, ec, kv, ki);
    checkOutput("t4_exec_count", ec, 8);
    execSeen = 0; idx8 = -1;
    foreach (traceInst[k])
      if (traceInst[k] == INST_EXEC) begin
        execSeen++;
        if (execSeen == 8) idx8 = k;
      end
    checkOutput("t4_ready_after_8th", (idx8 >= 0) ? traceRdy[idx8] : 1'b1, 1'b0);
    checkOutput("t4_done_delay", d, 13);

    // start pulsed mid-EXEC and again while done is high
    doneBefore = doneCount;
    runJob(8, 0, 0, 1, 1, 0, d);
    countTrace(kc, ec, kv, ki);
    checkOutput("t5_exec_count", ec, 8);
    checkOutput("t5_jobs_done", doneCount - doneBefore, 1);
    checkOutput("t5_busy_after", busy, 1'b0);
    checkOutput("t5_done_delay", d, 13);

    // Asynchronous reset with Q_5 in flight, then a clean job
    runJob(8, 0, 0, 0, 0, 5, d);
    runJob(8, 0, 0, 0, 0, 0, d);
    countTrace(kc, ec, kv, ki);
    checkOutput("t6_exec_count", ec, 8);
    checkOutput("t6_kload_val", kv, 64'h0101_0101_0101_0101);
    checkOutput("t6_done_delay", d, 13);

    // Random jobs with random valid and data
    for (int r = 0; r < 6; r++) begin
      nq = $urandom_range(0, 15);
      nqc = (nq > TC) ? TC : nq;
      runJob(nq, 0, 1, 0, 0, 0, d);
      countTrace(kc, ec, kv, ki);
      checkOutput("rand_exec_count", ec, nqc);
      checkOutput("rand_kload_count", kc, 1);
      checkOutput("rand_delay_min", d >= (nqc + CL + 2), 1'b1);
    end

    repeat (3) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_col_driver.md
# mac_col_driver

Issue-side sequencer for the MAC column (`mac_col_new`): it accepts a stream of pr-lane vectors on a valid/ready handshake and drives the column's `q_in`/`i_inst` pair. It emits one kernel-load vector followed by a programmable number of query-execute vectors, inserting NOP bubbles when upstream stalls. It then waits for the column pipeline to drain and reports completion. It sits between the Q/K buffer readout and the first column of the MAC array.

## Interface
- `bw`, 8, bits per lane element
- `pr`, 8, lanes per vector
- `total_cycle`, 8, maximum Q vectors per job; `n_q` width is clog2(total_cycle+1)
- `col_lat`, 3, column pipeline depth in cycles, waited out before `done`
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `start` in 1: one-cycle job request, honoured only in IDLE
- `n_q` in clog2(total_cycle+1): Q vectors for the job, sampled on accepted `start`
- `vec_in` in pr*bw: lane vector, lane 0 in bits [bw-1:0]
- `vec_valid` in 1: `vec_in` valid
- `vec_ready` out 1: driver accepts `vec_in` this cycle
- `q_out` out pr*bw: to column `q_in`
- `inst_out` out 2: to column `i_inst`
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle completion pulse

## Operation
- Instruction codes: NOP = 2'b00, KLOAD = 2'b01, EXEC = 2'b10; 2'b11 is never driven.
- States:
  - IDLE: entered on reset. On `start`, latch `n_q`, clear `q_cnt`, and go to LOAD.
  - LOAD: `vec_ready`=1. On handshake, register `vec_in` to `q_out` with `inst_out`=KLOAD. Go to EXEC, or to DRAIN if the latched `n_q`=0.
  - EXEC: `vec_ready`=1.
    - On handshake: `q_out`=`vec_in`, `inst_out`=EXEC, `q_cnt`++. When `q_cnt` reaches `n_q`, go to DRAIN.
    - With no handshake: `inst_out`=NOP and `q_out` holds its last value.
  - DRAIN: `vec_ready`=0 and `inst_out`=NOP. Count `col_lat` cycles, then assert `done` for one cycle and return to IDLE.
- In LOAD with no handshake: `inst_out`=NOP.
- `vec_ready` is decoded from the state register only. It never depends on `vec_valid`, so there is no combinational path from input to output.
- `n_q` > `total_cycle` is clamped to `total_cycle` at latch time.
- `start` while `busy`: ignored, with no effect on the running job.
- `start` in the same cycle that `done` is high: the FSM is still in DRAIN, so `start` is ignored. The earliest accepted `start` is the cycle after `done`.
- `vec_valid` asserted in IDLE or DRAIN: no handshake; the data is neither consumed nor dropped.
- Reset mid-job: FSM goes to IDLE immediately. The job is abandoned, and the column sees NOP from that point on.

## Timing
- Reset values: `q_out`=0, `inst_out`=NOP, `vec_ready`=0, `busy`=0, `done`=0, `q_cnt`=0, drain counter=0.
- Latency: a handshake at edge t makes `q_out`/`inst_out` valid from t until t+1, with exactly one cycle of latency. All data outputs are registered.
- `start` sampled at edge t: `busy` and `vec_ready` are high after t.
- Back-to-back handshakes issue one instruction per cycle, with no bubbles.
- With n Q vectors and no stalls, `done` asserts 1 (LOAD) + n (EXEC) + `col_lat` + 1 cycles after the `start` edge.
- `done` falls, and `busy` with it, at the edge after `done` rises.

## Structure
- Shared package `mac_pkg`:
  - instruction constants INST_NOP, INST_KLOAD, INST_EXEC
  - 2-bit state enum IDLE/LOAD/EXEC/DRAIN
  - `bw`/`pr` defaults shared with `mac_col_new`
- No sub-module is natural. The FSM, the two counters and the output register live in one module of about 150–200 lines.

## Test plan
- Reset, then `start` with `n_q`=8 and `vec_valid` held high. Vectors: K = lanes all 8'h01, then Q_i = lanes all i (i=1..8). Required:
  - KLOAD with 64'h0101_0101_0101_0101 appears one cycle after the first handshake.
  - Eight consecutive EXEC cycles follow, with lanes all 1..8.
  - `done` pulses exactly 13 cycles after `start` (`col_lat`=3).
- Same job with `vec_valid` low for 2 cycles after Q_3. Required: exactly 2 NOP cycles between EXEC(Q_3) and EXEC(Q_4), with `q_out` holding Q_3's value during the NOPs, and `done` delayed by 2 cycles.
- `n_q`=0. Required: one KLOAD, no EXEC, and `done` 5 cycles after `start`.
- `n_q`=12 with `total_cycle`=8. Required: only 8 EXEC issues, and `vec_ready` low after the 8th Q.
- `start` pulsed mid-EXEC, then pulsed again in the cycle `done` is high. Required: both ignored, job count unaffected, `busy` low the following cycle.
- `reset` asserted between edges while Q_5 is in flight. Required: outputs go to reset values immediately (asynchronously). A fresh `start` then runs a complete job correctly.
